// File: rtl/spawn_scheduler_pkg.sv
// spawn_scheduler_pkg: scheduler states, default wave constants and counter width
package spawn_scheduler_pkg;
  localparam int CNT_W = 8;
  localparam int DEF_LEVEL_W = 4;
  localparam int DEF_COUNT_W = 4;
  localparam int DEF_MAX_OBJECTS = 8;
  localparam int DEF_BASE_INTERVAL = 50;
  localparam int DEF_INTERVAL_STEP = 4;
  localparam int DEF_MIN_INTERVAL = 10;
  localparam int DEF_BASE_QUOTA = 6;
  localparam int DEF_QUOTA_STEP = 2;
  localparam int DEF_BURST_LEVEL = 4;
  typedef enum logic [2:0] {IDLE, WAIT, CHECK, REQ, DONE} SchedState;
endpackage

// File: rtl/spawn_scheduler_if.sv
// spawn_scheduler_if: control-FSM / event-core signals around the spawn scheduler
interface spawn_scheduler_if import spawn_scheduler_pkg::*; #(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int COUNT_W = DEF_COUNT_W
);
  logic tick;
  logic en;
  logic level_start;
  logic [LEVEL_W-1:0] cur_level;
  logic [COUNT_W-1:0] object_count;
  logic spawn_ack;
  logic spawn_req;
  logic [CNT_W-1:0] spawn_index;
  logic [CNT_W-1:0] quota_remaining;
  logic wave_done;
  logic busy;
  modport master (
    output tick, en, level_start, cur_level, object_count, spawn_ack,
    input spawn_req, spawn_index, quota_remaining, wave_done, busy
  );
  modport slave (
    input tick, en, level_start, cur_level, object_count, spawn_ack,
    output spawn_req, spawn_index, quota_remaining, wave_done, busy
  );
endinterface

// File: rtl/spawn_scheduler_profile.sv
// spawn_profile: level -> spawn interval (signed, floored) and quota (saturated)
module spawn_profile import spawn_scheduler_pkg::*; #(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int BASE_INTERVAL = DEF_BASE_INTERVAL,
  parameter int INTERVAL_STEP = DEF_INTERVAL_STEP,
  parameter int MIN_INTERVAL = DEF_MIN_INTERVAL,
  parameter int BASE_QUOTA = DEF_BASE_QUOTA,
  parameter int QUOTA_STEP = DEF_QUOTA_STEP
) (
  input  logic [LEVEL_W-1:0] i_level,
  output logic [CNT_W-1:0]   o_interval,
  output logic [CNT_W-1:0]   o_quota
);
  logic signed [9:0] w_interval;
  logic [8:0] w_quota;
  always_comb begin
    w_interval = 10'(BASE_INTERVAL) - 10'(INTERVAL_STEP) * 10'(i_level);
    w_quota = 9'(BASE_QUOTA) + 9'(QUOTA_STEP) * 9'(i_level);
    o_interval = w_interval < $signed(10'(MIN_INTERVAL)) ? 8'(MIN_INTERVAL) : w_interval[7:0];
    o_quota = w_quota[8] ? 8'hFF : w_quota[7:0];
  end
endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: paces one wave of alien spawns into the event core via req/ack.
// Build option SPAWN_BURST_EN: from BURST_LEVEL up, spawns come in pairs one tick apart.
module spawn_scheduler import spawn_scheduler_pkg::*; #(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int MAX_OBJECTS = DEF_MAX_OBJECTS,
  parameter int BASE_INTERVAL = DEF_BASE_INTERVAL,
  parameter int INTERVAL_STEP = DEF_INTERVAL_STEP,
  parameter int MIN_INTERVAL = DEF_MIN_INTERVAL,
  parameter int BASE_QUOTA = DEF_BASE_QUOTA,
  parameter int QUOTA_STEP = DEF_QUOTA_STEP
`ifdef SPAWN_BURST_EN
  , parameter int BURST_LEVEL = DEF_BURST_LEVEL
`endif
) (
  input logic clk_main,
  input logic rst,
  spawn_scheduler_if.slave bus
);
  SchedState r_state, w_state_n;
  logic [CNT_W-1:0] r_cd, w_cd_n, r_quota, w_quota_n, r_index, w_index_n;
  logic [CNT_W-1:0] r_interval, w_interval, w_quota, w_reload;
  logic r_req, r_full;
  spawn_profile #(
    .LEVEL_W(LEVEL_W), .BASE_INTERVAL(BASE_INTERVAL), .INTERVAL_STEP(INTERVAL_STEP),
    .MIN_INTERVAL(MIN_INTERVAL), .BASE_QUOTA(BASE_QUOTA), .QUOTA_STEP(QUOTA_STEP)
  ) u_profile (
    .i_level(bus.cur_level),
    .o_interval(w_interval),
    .o_quota(w_quota)
  );
`ifdef SPAWN_BURST_EN
  logic r_burst;
  always_ff @(posedge clk_main or posedge rst)
    if (rst) r_burst <= 1'b0;
    else if (bus.level_start) r_burst <= bus.cur_level >= LEVEL_W'(BURST_LEVEL);
  // an even index before the ack means the spawn being completed is the first of a pair
  assign w_reload = r_burst && !r_index[0] ? 8'd1 : r_interval;
`else
  assign w_reload = r_interval;
`endif
  always_ff @(posedge clk_main or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cd <= '0;
      r_quota <= '0;
      r_index <= '0;
      r_interval <= '0;
      r_req <= 1'b0;
      r_full <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cd <= w_cd_n;
      r_quota <= w_quota_n;
      r_index <= w_index_n;
      r_interval <= bus.level_start ? w_interval : r_interval;
      r_req <= w_state_n == REQ && bus.en;
      r_full <= bus.object_count >= COUNT_W'(MAX_OBJECTS);
    end
  always_comb begin
    w_state_n = r_state;
    w_cd_n = r_cd;
    w_quota_n = r_quota;
    w_index_n = r_index;
    if (bus.level_start) begin
      w_state_n = w_quota == '0 ? DONE : WAIT;
      w_cd_n = w_interval;
      w_quota_n = w_quota;
      w_index_n = '0;
    end else if (bus.en)
      case (r_state)
        WAIT: begin
          w_state_n = r_cd == '0 ? CHECK : WAIT;
          w_cd_n = bus.tick && r_cd != '0 ? r_cd - 1'b1 : r_cd;
        end
        CHECK: w_state_n = r_full ? CHECK : REQ;
        REQ: if (bus.spawn_ack) begin
          w_quota_n = r_quota - 1'b1;
          w_index_n = r_index + 1'b1;
          w_state_n = r_quota == 8'd1 ? DONE : WAIT;
          w_cd_n = w_reload;
        end
        default: ;
      endcase
  end
  assign bus.spawn_req = r_req;
  assign bus.spawn_index = r_index;
  assign bus.quota_remaining = r_quota;
  assign bus.wave_done = r_state == DONE;
  assign bus.busy = r_state != IDLE && r_state != DONE;
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: randomized waves checked against an arithmetic model of the wave rules
module tb_spawn_scheduler;
  logic clk_main = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int m_level, m_quota, m_index;
  spawn_scheduler_if bus();
  spawn_scheduler dut (.clk_main(clk_main), .rst(rst), .bus(bus));
  always #5 clk_main = ~clk_main;

  function automatic int interval_of(input int lvl);
    int v = 50 - 4 * lvl;
    return v < 10 ? 10 : v;
  endfunction
  function automatic int quota_of(input int lvl);
    int q = 6 + 2 * lvl;
    return q > 255 ? 255 : q;
  endfunction
  function automatic int gap_after(input int lvl, input int idx);
`ifdef SPAWN_BURST_EN
    if (lvl >= 4 && idx % 2 == 1) return 1;
`endif
    return interval_of(lvl);
  endfunction

  task automatic step;
    @(posedge clk_main);
    #1;
  endtask

  task automatic start_wave(input int lvl, input logic with_ack, input string tag);
    bus.cur_level = 4'(lvl);
    bus.object_count = 4'($urandom_range(0, 7));
    bus.level_start = 1'b1;
    bus.spawn_ack = with_ack;
    step;
    bus.level_start = 1'b0;
    bus.spawn_ack = 1'b0;
    m_level = lvl;
    m_quota = quota_of(lvl);
    m_index = 0;
    n_vec++; if (bus.quota_remaining !== 8'(m_quota)) begin n_err++; $display("FAIL %s start_quota: got %0d required %0d", tag, bus.quota_remaining, m_quota); end
    n_vec++; if (bus.spawn_index !== 8'd0) begin n_err++; $display("FAIL %s start_index: got %0d required 0", tag, bus.spawn_index); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL %s start_busy: got %b required 1", tag, bus.busy); end
    n_vec++; if (bus.spawn_req !== 1'b0 || bus.wave_done !== 1'b0) begin n_err++; $display("FAIL %s start_outputs: req=%b done=%b required 0 0", tag, bus.spawn_req, bus.wave_done); end
  endtask

  task automatic wait_spawn(input int ticks, input logic room, input string tag);
    int got = 0;
    int guard = 0;
    while (got < ticks && guard < 3000) begin
      bus.tick = 1'($urandom_range(0, 1));
      bus.en = $urandom_range(0, 3) != 0;
      bus.spawn_ack = $urandom_range(0, 3) == 0;
      bus.cur_level = 4'($urandom);
      if (bus.tick && bus.en) got++;
      guard++;
      step;
      n_vec++; if (bus.spawn_req !== 1'b0) begin n_err++; $display("FAIL %s early_req: got %b required 0 after %0d of %0d ticks", tag, bus.spawn_req, got, ticks); end
    end
    n_vec++; if (got < ticks) begin n_err++; $display("FAIL %s tick_budget: delivered %0d required %0d", tag, got, ticks); end
    bus.tick = 1'($urandom_range(0, 1));
    bus.spawn_ack = 1'($urandom_range(0, 1));
    bus.en = 1'b1;
    step;
    n_vec++; if (bus.spawn_req !== 1'b0) begin n_err++; $display("FAIL %s req_plus1: got %b required 0", tag, bus.spawn_req); end
    bus.tick = 1'($urandom_range(0, 1));
    bus.spawn_ack = 1'($urandom_range(0, 1));
    step;
    bus.tick = 1'b0;
    bus.spawn_ack = 1'b0;
    n_vec++; if (bus.spawn_req !== room) begin n_err++; $display("FAIL %s req_plus2: got %b required %b", tag, bus.spawn_req, room); end
  endtask

  task automatic do_ack(input string tag);
    bus.spawn_ack = 1'b1;
    step;
    bus.spawn_ack = 1'b0;
    m_quota--;
    m_index++;
    n_vec++; if (bus.spawn_req !== 1'b0) begin n_err++; $display("FAIL %s ack_req: got %b required 0", tag, bus.spawn_req); end
    n_vec++; if (bus.quota_remaining !== 8'(m_quota)) begin n_err++; $display("FAIL %s ack_quota: got %0d required %0d", tag, bus.quota_remaining, m_quota); end
    n_vec++; if (bus.spawn_index !== 8'(m_index)) begin n_err++; $display("FAIL %s ack_index: got %0d required %0d", tag, bus.spawn_index, m_index); end
    n_vec++; if (bus.wave_done !== (m_quota == 0) || bus.busy !== (m_quota != 0)) begin n_err++; $display("FAIL %s ack_status: done=%b busy=%b required %b %b", tag, bus.wave_done, bus.busy, m_quota == 0, m_quota != 0); end
  endtask

  task automatic run_spawns(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      bus.object_count = 4'($urandom_range(0, 7));
      wait_spawn(m_index == 0 ? interval_of(m_level) : gap_after(m_level, m_index), 1'b1, tag);
      do_ack(tag);
    end
  endtask

  task automatic test_reset;
    bus.tick = 1'b0; bus.en = 1'b1; bus.level_start = 1'b0; bus.cur_level = '0;
    bus.object_count = '0; bus.spawn_ack = 1'b0;
    step;
    step;
    n_vec++; if (bus.spawn_req !== 1'b0 || bus.wave_done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_flags: req=%b done=%b busy=%b required 0 0 0", bus.spawn_req, bus.wave_done, bus.busy); end
    n_vec++; if (bus.spawn_index !== 8'd0 || bus.quota_remaining !== 8'd0) begin n_err++; $display("FAIL reset_counts: index=%0d quota=%0d required 0 0", bus.spawn_index, bus.quota_remaining); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.tick = 1'($urandom_range(0, 1));
      bus.spawn_ack = 1'($urandom_range(0, 1));
      step;
      n_vec++; if (bus.busy !== 1'b0 || bus.spawn_req !== 1'b0 || bus.quota_remaining !== 8'd0) begin n_err++; $display("FAIL idle_hold: busy=%b req=%b quota=%0d required 0 0 0", bus.busy, bus.spawn_req, bus.quota_remaining); end
    end
    bus.tick = 1'b0;
    bus.spawn_ack = 1'b0;
  endtask

  task automatic test_level0;
    start_wave(0, 1'b0, "lvl0");
    run_spawns(6, "lvl0");
    for (int i = 0; i < 10; i++) begin
      bus.tick = 1'($urandom_range(0, 1));
      bus.spawn_ack = 1'($urandom_range(0, 1));
      step;
      n_vec++; if (bus.wave_done !== 1'b1 || bus.spawn_req !== 1'b0 || bus.quota_remaining !== 8'd0) begin n_err++; $display("FAIL done_hold: done=%b req=%b quota=%0d required 1 0 0", bus.wave_done, bus.spawn_req, bus.quota_remaining); end
    end
    bus.tick = 1'b0;
    bus.spawn_ack = 1'b0;
  endtask

  task automatic test_profile;
    start_wave(15, 1'b0, "lvl15");
    run_spawns(2, "lvl15");
    start_wave(10, 1'b0, "lvl10");
    run_spawns(2, "lvl10");
    for (int i = 0; i < 5; i++) begin
      start_wave($urandom_range(0, 15), 1'b0, "rand_lvl");
      run_spawns(1, "rand_lvl");
    end
  endtask

  task automatic test_capacity;
    start_wave(1, 1'b0, "cap");
    bus.object_count = 4'd8;
    wait_spawn(interval_of(1), 1'b0, "cap_full");
    for (int i = 0; i < int'($urandom_range(3, 20)); i++) begin
      bus.object_count = 4'($urandom_range(8, 15));
      step;
      n_vec++; if (bus.spawn_req !== 1'b0) begin n_err++; $display("FAIL cap_stall: got %b required 0", bus.spawn_req); end
    end
    bus.object_count = 4'd7;
    step;
    n_vec++; if (bus.spawn_req !== 1'b0) begin n_err++; $display("FAIL cap_release1: got %b required 0", bus.spawn_req); end
    step;
    n_vec++; if (bus.spawn_req !== 1'b1) begin n_err++; $display("FAIL cap_release2: got %b required 1", bus.spawn_req); end
    do_ack("cap");
  endtask

  task automatic test_en_drop;
    start_wave(3, 1'b0, "en");
    run_spawns(1, "en");
    wait_spawn(gap_after(3, m_index), 1'b1, "en");
    bus.en = 1'b0;
    for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
      bus.tick = 1'($urandom_range(0, 1));
      bus.spawn_ack = 1'($urandom_range(0, 1));
      step;
      n_vec++; if (bus.spawn_req !== 1'b0) begin n_err++; $display("FAIL en_low_req: got %b required 0", bus.spawn_req); end
      n_vec++; if (bus.quota_remaining !== 8'(m_quota) || bus.spawn_index !== 8'(m_index)) begin n_err++; $display("FAIL en_low_counts: quota=%0d index=%0d required %0d %0d", bus.quota_remaining, bus.spawn_index, m_quota, m_index); end
    end
    bus.en = 1'b1;
    bus.tick = 1'b0;
    bus.spawn_ack = 1'b0;
    step;
    n_vec++; if (bus.spawn_req !== 1'b1) begin n_err++; $display("FAIL en_resume: got %b required 1", bus.spawn_req); end
    do_ack("en");
  endtask

  task automatic test_collision;
    start_wave($urandom_range(5, 15), 1'b0, "pre_coll");
    wait_spawn(interval_of(m_level), 1'b1, "pre_coll");
    start_wave(2, 1'b1, "coll");
    run_spawns(1, "coll");
  endtask

  task automatic test_long_wave;
    start_wave(4, 1'b0, "lvl4");
    run_spawns(14, "lvl4");
  endtask

  initial begin
    test_reset;
    test_level0;
    test_profile;
    test_capacity;
    test_en_drop;
    test_collision;
    test_long_wave;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
